// File: rtl/sparc_pkg.sv
// Shared SPARC control-transfer definitions: condition encodings, PC mux selects, resolver states.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package sparc_pkg;

    // Bicc condition field (instruction bits [28:25]); bit 3 inverts the base test.
    localparam logic [3:0] COND_BN   = 4'b0000;
    localparam logic [3:0] COND_BE   = 4'b0001;
    localparam logic [3:0] COND_BLE  = 4'b0010;
    localparam logic [3:0] COND_BL   = 4'b0011;
    localparam logic [3:0] COND_BLEU = 4'b0100;
    localparam logic [3:0] COND_BCS  = 4'b0101;
    localparam logic [3:0] COND_BNEG = 4'b0110;
    localparam logic [3:0] COND_BVS  = 4'b0111;
    localparam logic [3:0] COND_BA   = 4'b1000;
    localparam int         COND_NEG_BIT = 3;

    // PC mux select
    localparam logic [1:0] PCSEL_NPC = 2'b00;
    localparam logic [1:0] PCSEL_TA  = 2'b01;
    localparam logic [1:0] PCSEL_ALU = 2'b10;

    typedef enum logic [1:0] {
        ST_NORMAL = 2'b00,
        ST_SLOT   = 2'b01,
        ST_ANNUL  = 2'b10
    } br_state_t;

endpackage

// File: rtl/cond_eval.sv
// Evaluates a Bicc condition field against icc {N,Z,V,C}; shared with trap-condition logic.
// Latency: purely combinational.
// Backpressure: none.
// Ports: cond (4) condition field, icc (4) condition codes, taken (1) condition true.
module cond_eval
    import sparc_pkg::*;
(
    input  logic [3:0] cond,
    input  logic [3:0] icc,
    output logic       taken
);

    logic n, z, v, c;
    logic base;

    assign {n, z, v, c} = icc;

    always_comb begin
        base = 1'b0;
        case (cond[2:0])
            COND_BN[2:0]:   base = 1'b0;
            COND_BE[2:0]:   base = z;
            COND_BLE[2:0]:  base = z | (n ^ v);
            COND_BL[2:0]:   base = n ^ v;
            COND_BLEU[2:0]: base = c | z;
            COND_BCS[2:0]:  base = c;
            COND_BNEG[2:0]: base = n;
            COND_BVS[2:0]:  base = v;
            default:        base = 1'b0;
        endcase
    end

    // Upper half of the encoding is the complement of the lower half (BN -> BA, BE -> BNE, ...).
    assign taken = cond[COND_NEG_BIT] ^ base;

endmodule

// File: rtl/branch_resolver.sv
// Holds icc, resolves Bicc/call/jmpl in ID to a PC mux select, sequences delay-slot annulment.
// Latency: pc_mux_select combinational from ID; cu_nop registered (one cycle after annulling branch).
// Backpressure: le=0 freezes icc and state; outputs still follow current inputs.
// Ports: clk, clr (async active-low), le, ex_cc_enable/ex_flags (EX icc write),
//        id_branch/id_call/id_jmpl/id_cond/id_annul (ID decode), pc_mux_select, cu_nop, icc.
// Option: BRANCH_RESOLVER_ICC_BYPASS_EN lets a branch in ID see flags produced in EX this cycle.
module branch_resolver
    import sparc_pkg::*;
#(
    parameter int CC_W = 4
) (
    input  logic            clk,
    input  logic            clr,
    input  logic            le,
    input  logic            ex_cc_enable,
    input  logic [CC_W-1:0] ex_flags,
    input  logic            id_branch,
    input  logic            id_call,
    input  logic            id_jmpl,
    input  logic [3:0]      id_cond,
    input  logic            id_annul,
    output logic [1:0]      pc_mux_select,
    output logic            cu_nop,
    output logic [CC_W-1:0] icc
);

    br_state_t       state_q, state_d;
    logic [CC_W-1:0] icc_q;
    logic [CC_W-1:0] icc_eff;
    logic            cond_true;
    logic            taken;
    logic            annul_req;

`ifdef BRANCH_RESOLVER_ICC_BYPASS_EN
    assign icc_eff = ex_cc_enable ? ex_flags : icc_q;
`else
    assign icc_eff = icc_q;
`endif

    cond_eval u_cond_eval (
        .cond  (id_cond),
        .icc   (icc_eff),
        .taken (cond_true)
    );

    assign taken = id_branch & cond_true;

    // Annul the delay slot when a=1 and the branch falls through; BA,a annuls even though taken.
    assign annul_req = id_branch & id_annul & (~taken | (id_cond == COND_BA));

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            icc_q   <= '0;
            state_q <= ST_NORMAL;
        end else if (le) begin
            if (ex_cc_enable) begin
                icc_q <= ex_flags;
            end
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        pc_mux_select = PCSEL_NPC;
        case (state_q)
            ST_ANNUL: begin
                // Slot instruction is squashed: decode flags ignored, fall through to nPC.
                state_d = ST_NORMAL;
            end
            ST_NORMAL, ST_SLOT: begin
                // Decode-flag conflicts resolve jmpl > call > branch.
                if (id_jmpl) begin
                    pc_mux_select = PCSEL_ALU;
                end else if (id_call || taken) begin
                    pc_mux_select = PCSEL_TA;
                end

                // SLOT re-enters the same evaluation so a DCTI couple resolves naturally.
                if (id_jmpl || id_call) begin
                    state_d = ST_SLOT;
                end else if (annul_req) begin
                    state_d = ST_ANNUL;
                end else if (taken) begin
                    state_d = ST_SLOT;
                end else begin
                    state_d = ST_NORMAL;
                end
            end
            default: state_d = ST_NORMAL;
        endcase
        // Keep the PC on nPC for as long as reset is held.
        if (!clr) begin
            pc_mux_select = PCSEL_NPC;
        end
    end

    assign cu_nop = (state_q == ST_ANNUL);
    assign icc    = icc_q;

endmodule
